hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, data-memory
// freezes and halt/resume, plus saturating stall/flush statistics counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_load,
    input  logic             ex_w_en,
    input  logic [4:0]       ex_req_w,
    input  logic             ex_redirect,
    input  logic             dm_wait,
    input  logic             wb_halt,
    input  logic             go,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_dm_en,
    output logic             dm_wb_en,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             ex_dm_clr,
    output logic             dm_wb_clr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;
    logic             load_use;

    // Register 0 is hardwired to zero, so a load targeting it never hazards.
    assign load_use = ex_load && ex_w_en && (ex_req_w != 5'd0) &&
                      ((id_rs_used && (id_rs == ex_req_w)) ||
                       (id_rt_used && (id_rt == ex_req_w)));

    // Gated by rst_n so the pipeline sees the plain advance pattern in reset.
    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_dm_en  = 1'b1;
        dm_wb_en  = 1'b1;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        ex_dm_clr = 1'b1;
        dm_wb_clr = 1'b1;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (wb_halt) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        ex_dm_en = 1'b0;
                        dm_wb_en = 1'b0;
                        state_d  = HALT;
                    end else if (dm_wait) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_dm_en  = 1'b0;
                        dm_wb_clr = 1'b0;
                        stall_inc = 1'b1;
                    end else if (ex_redirect) begin
                        if_id_clr = 1'b0;
                        id_ex_clr = 1'b0;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_clr = 1'b0;
                        stall_inc = 1'b1;
                    end
                end
                HALT: begin
                    if (go) begin
                        dm_wb_clr = 1'b0;
                        state_d   = RUN;
                    end else begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        ex_dm_en = 1'b0;
                        dm_wb_en = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard testbench for hazard_ctrl: directed cycles push expected responses,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam logic [8:0] DEFAULT_P = 9'b1_1111_1111;
    localparam logic [8:0] FREEZE_P  = 9'b0_0000_1111;
    localparam logic [8:0] DMWAIT_P  = 9'b0_0001_1110;
    localparam logic [8:0] FLUSH_P   = 9'b1_1111_0011;
    localparam logic [8:0] LU_P      = 9'b0_0111_1011;
    localparam logic [8:0] GO_P      = 9'b1_1111_1110;

    typedef struct {
        string       name;
        logic [8:0]  comb;
        logic        halted;
        logic [15:0] stall;
        logic [15:0] flush;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_req_w;
    logic        id_rs_used, id_rt_used, ex_load, ex_w_en;
    logic        ex_redirect, dm_wait, wb_halt, go;
    logic        pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
    logic        if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr;
    logic        halted;
    logic [15:0] stall_cnt, flush_cnt;

    expect_t     scoreboard[$];
    int          testsRun;
    int          failCount;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .ex_load    (ex_load),
        .ex_w_en    (ex_w_en),
        .ex_req_w   (ex_req_w),
        .ex_redirect(ex_redirect),
        .dm_wait    (dm_wait),
        .wb_halt    (wb_halt),
        .go         (go),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .id_ex_en   (id_ex_en),
        .ex_dm_en   (ex_dm_en),
        .dm_wb_en   (dm_wb_en),
        .if_id_clr  (if_id_clr),
        .id_ex_clr  (id_ex_clr),
        .ex_dm_clr  (ex_dm_clr),
        .dm_wb_clr  (dm_wb_clr),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares the DUT's present outputs against one scoreboard entry.
    task automatic checkOutput(input expect_t e);
        logic [41:0] act;
        logic [41:0] req;
        act = {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
               if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr,
               halted, stall_cnt, flush_cnt};
        req = {e.comb, e.halted, e.stall, e.flush};
        testsRun++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got ctl=%b halted=%b stall=%h flush=%h, expected ctl=%b halted=%b stall=%h flush=%h",
                     e.name, act[41:33], act[32], act[31:16], act[15:0],
                     e.comb, e.halted, e.stall, e.flush);
        end
    endtask

    // Monitor: mid-cycle, after inputs have settled, pop and check.
    always @(negedge clk) begin
        if (scoreboard.size() != 0) begin
            checkOutput(scoreboard.pop_front());
        end
    end

    task automatic pushExpect(input string name, input logic [8:0] comb,
                              input logic h, input logic [15:0] s,
                              input logic [15:0] f);
        expect_t e;
        e.name   = name;
        e.comb   = comb;
        e.halted = h;
        e.stall  = s;
        e.flush  = f;
        scoreboard.push_back(e);
    endtask

    // Drives one cycle of inputs just after the rising edge and queues the
    // expected response for that cycle.
    task automatic applyStimulus(input string name,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rsUsed, input logic rtUsed,
                                 input logic load, input logic wen,
                                 input logic [4:0] reqW, input logic redirect,
                                 input logic dmWait, input logic halt,
                                 input logic goIn,
                                 input logic [8:0] expComb, input logic expHalted,
                                 input logic [15:0] expStall,
                                 input logic [15:0] expFlush);
        @(posedge clk);
        #1;
        id_rs       = rs;
        id_rt       = rt;
        id_rs_used  = rsUsed;
        id_rt_used  = rtUsed;
        ex_load     = load;
        ex_w_en     = wen;
        ex_req_w    = reqW;
        ex_redirect = redirect;
        dm_wait     = dmWait;
        wb_halt     = halt;
        go          = goIn;
        pushExpect(name, expComb, expHalted, expStall, expFlush);
    endtask

    task automatic idleCycle(input string name, input logic [8:0] expComb,
                             input logic expHalted, input logic [15:0] expStall,
                             input logic [15:0] expFlush);
        applyStimulus(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, expComb, expHalted, expStall, expFlush);
    endtask

    // Asserts reset mid-cycle with hostile inputs; outputs must clear at once.
    task automatic applyReset(input string name);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        id_rs       = 5'd3;
        id_rt       = 5'd3;
        id_rs_used  = 1'b1;
        id_rt_used  = 1'b1;
        ex_load     = 1'b1;
        ex_w_en     = 1'b1;
        ex_req_w    = 5'd3;
        ex_redirect = 1'b1;
        dm_wait     = 1'b1;
        wb_halt     = 1'b1;
        go          = 1'b1;
        pushExpect(name, DEFAULT_P, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst_n       = 1'b1;
        id_rs_used  = 1'b0;
        id_rt_used  = 1'b0;
        ex_load     = 1'b0;
        ex_w_en     = 1'b0;
        ex_redirect = 1'b0;
        dm_wait     = 1'b0;
        wb_halt     = 1'b0;
        go          = 1'b0;
    endtask

    task automatic holdDmWait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            id_rs_used  = 1'b0;
            id_rt_used  = 1'b0;
            ex_load     = 1'b0;
            ex_w_en     = 1'b0;
            ex_redirect = 1'b0;
            wb_halt     = 1'b0;
            go          = 1'b0;
            dm_wait     = 1'b1;
        end
    endtask

    initial begin
        testsRun    = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_rs_used  = 1'b0;
        id_rt_used  = 1'b0;
        ex_load     = 1'b0;
        ex_w_en     = 1'b0;
        ex_req_w    = 5'd0;
        ex_redirect = 1'b0;
        dm_wait     = 1'b0;
        wb_halt     = 1'b0;
        go          = 1'b0;

        applyReset("reset_default");
        releaseReset();

        idleCycle("idle_after_reset", DEFAULT_P, 1'b0, 16'd0, 16'd0);
        applyStimulus("lu_r0_ignored", 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_P, 1'b0, 16'd0, 16'd0);
        applyStimulus("lu_rs", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'd0, 16'd0);
        idleCycle("after_lu_rs", DEFAULT_P, 1'b0, 16'd1, 16'd0);
        applyStimulus("lu_rt", 5'd9, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'd1, 16'd0);
        applyStimulus("rt_not_used", 5'd9, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,
                      1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_P, 1'b0, 16'd2, 16'd0);
        applyStimulus("no_wen", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,
                      1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_P, 1'b0, 16'd2, 16'd0);
        applyStimulus("lu_plus_redirect", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,
                      1'b1, 1'b0, 1'b0, 1'b0, FLUSH_P, 1'b0, 16'd2, 16'd0);
        idleCycle("after_flush", DEFAULT_P, 1'b0, 16'd2, 16'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus("dmwait_redirect", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                          1'b1, 1'b1, 1'b0, 1'b0, DMWAIT_P, 1'b0,
                          16'(2 + i), 16'd1);
        end
        applyStimulus("deferred_redirect", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b1, 1'b0, 1'b0, 1'b0, FLUSH_P, 1'b0, 16'd5, 16'd1);
        idleCycle("after_deferred", DEFAULT_P, 1'b0, 16'd5, 16'd2);
        applyStimulus("dmwait_over_lu", 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7,
                      1'b0, 1'b1, 1'b0, 1'b0, DMWAIT_P, 1'b0, 16'd5, 16'd2);
        idleCycle("after_dmwait_lu", DEFAULT_P, 1'b0, 16'd6, 16'd2);

        applyStimulus("halt_over_redirect", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b1, 1'b0, 1'b1, 1'b0, FREEZE_P, 1'b0, 16'd6, 16'd2);
        applyStimulus("halt_ignores_events", 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,
                      1'b1, 1'b1, 1'b0, 1'b0, FREEZE_P, 1'b1, 16'd6, 16'd2);
        for (int i = 0; i < 3; i++) begin
            idleCycle("halt_hold", FREEZE_P, 1'b1, 16'd6, 16'd2);
        end
        applyStimulus("go_resume", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, GO_P, 1'b1, 16'd6, 16'd2);
        idleCycle("after_go", DEFAULT_P, 1'b0, 16'd6, 16'd2);
        applyStimulus("go_in_run", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, DEFAULT_P, 1'b0, 16'd6, 16'd2);
        idleCycle("after_go_in_run", DEFAULT_P, 1'b0, 16'd6, 16'd2);

        holdDmWait(16'hFFFE - 6);
        idleCycle("preloaded", DEFAULT_P, 1'b0, 16'hFFFE, 16'd2);
        applyStimulus("sat_lu0", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'hFFFE, 16'd2);
        applyStimulus("sat_lu1", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'hFFFF, 16'd2);
        applyStimulus("sat_lu2", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'hFFFF, 16'd2);
        idleCycle("saturated", DEFAULT_P, 1'b0, 16'hFFFF, 16'd2);

        applyStimulus("halt_again", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                      1'b0, 1'b0, 1'b1, 1'b0, FREEZE_P, 1'b0, 16'hFFFF, 16'd2);
        idleCycle("halted_again", FREEZE_P, 1'b1, 16'hFFFF, 16'd2);
        applyReset("reset_mid_halt");
        releaseReset();
        idleCycle("after_reset_no_pending", DEFAULT_P, 1'b0, 16'd0, 16'd0);
        applyStimulus("lu_after_reset", 5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12,
                      1'b0, 1'b0, 1'b0, 1'b0, LU_P, 1'b0, 16'd0, 16'd0);
        idleCycle("final", DEFAULT_P, 1'b0, 16'd1, 16'd0);

        for (int i = 0; i < 10 && scoreboard.size() != 0; i++) begin
            @(posedge clk);
        end
        if (scoreboard.size() != 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
